// File: rtl/alu_disp_pkg.sv
// Shared types and constants for the ALU result display: FSM states and 7-segment codes.
// Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package alu_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [2:0] LAST_SHIFT = 3'd7;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alu_result_display_bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble, one bit per cycle).
// Latency 8 cycles in SHIFT; start is ignored while busy, no queueing.
module bin2bcd_seq
    import alu_disp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  bin,
    input  logic        neg_in,
    output logic        busy,
    output logic        done,
    output logic        load,
    output logic [11:0] bcd,
    output logic        neg
);

    state_t      state;
    state_t      state_nxt;
    logic [19:0] sr;
    logic [19:0] adj;
    logic [19:0] step;
    logic [2:0]  cnt;
    logic        accept;

    // One double-dabble step: correct each BCD nibble, then shift.
    always_comb begin
        adj = sr;
        for (int i = 0; i < 3; i++) begin
            if (sr[8+4*i +: 4] >= 4'd5) begin
                adj[8+4*i +: 4] = sr[8+4*i +: 4] + 4'd3;
            end
        end
        step = {adj[18:0], 1'b0};
    end

    // bcd is the post-step value so the top can capture it on the edge entering DONE.
    assign bcd = step[19:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (cnt == LAST_SHIFT) begin
                    load      = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_SHIFT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
            neg <= 1'b0;
        end else if (accept) begin
            sr  <= {12'd0, bin};
            cnt <= '0;
            neg <= neg_in && (bin != 8'd0);
        end else if (state == ST_SHIFT) begin
            sr  <= step;
            cnt <= cnt + 3'd1;
        end
    end

endmodule

// File: rtl/alu_result_display.sv
// Signed ALU result to 4-digit multiplexed 7-segment display with leading-zero blanking.
// New digits appear 8 cycles after res_valid; strobes during a conversion are dropped.
module alu_result_display
    import alu_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] opc,
    input  logic       signc,
    input  logic       res_valid,
    output logic       busy,
    output logic       done,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic          load;
    logic [11:0]   bcd;
    logic          neg;
    logic [3:0]    hund;
    logic [3:0]    tens;
    logic [3:0]    ones;
    logic          sign_show;
    logic [CW-1:0] refresh_cnt;
    logic [1:0]    digit_idx;
    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          blank_lz;

    assign blank_lz = (BLANK_LZ != 0);
    assign dp       = 1'b1;

    bin2bcd_seq u_conv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (res_valid),
        .bin    (opc),
        .neg_in (signc),
        .busy   (busy),
        .done   (done),
        .load   (load),
        .bcd    (bcd),
        .neg    (neg)
    );

    // Digits only ever change on the conversion-complete edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hund      <= '0;
            tens      <= '0;
            ones      <= '0;
            sign_show <= 1'b0;
        end else if (load) begin
            hund      <= bcd[11:8];
            tens      <= bcd[7:4];
            ones      <= bcd[3:0];
            sign_show <= neg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + CW'(1);
        end
    end

    always_comb begin
        an_nxt  = 4'b1110;
        seg_nxt = SEG_BLANK;
        case (digit_idx)
            2'd0: begin
                an_nxt  = 4'b1110;
                seg_nxt = seg_digit(ones);
            end
            2'd1: begin
                an_nxt  = 4'b1101;
                seg_nxt = (blank_lz && hund == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg_digit(tens);
            end
            2'd2: begin
                an_nxt  = 4'b1011;
                seg_nxt = (blank_lz && hund == 4'd0) ? SEG_BLANK : seg_digit(hund);
            end
            default: begin
                an_nxt  = 4'b0111;
                seg_nxt = sign_show ? SEG_MINUS : SEG_BLANK;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display: two instances (blanking on/off) share stimulus.
module tb_alu_result_display;

    localparam logic [6:0] BLK = 7'b1111111;
    localparam logic [6:0] MIN = 7'b0111111;
    localparam logic [6:0] S0  = 7'b1000000;
    localparam logic [6:0] S2  = 7'b0100100;
    localparam logic [6:0] S5  = 7'b0010010;
    localparam logic [6:0] S7  = 7'b1111000;
    localparam logic [6:0] S9  = 7'b0010000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] opc = 8'd0;
    logic       signc = 1'b0;
    logic       res_valid = 1'b0;
    logic       busy, done, dp;
    logic [3:0] an;
    logic [6:0] seg;
    logic       busy_b, done_b, dp_b;
    logic [3:0] an_b;
    logic [6:0] seg_b;

    int vec_cnt = 0;
    int mis_cnt = 0;

    always #5 clk = ~clk;

    alu_result_display #(.REFRESH_DIV(4), .BLANK_LZ(1)) dut (
        .clk(clk), .rst_n(rst_n), .opc(opc), .signc(signc), .res_valid(res_valid),
        .busy(busy), .done(done), .an(an), .seg(seg), .dp(dp)
    );

    alu_result_display #(.REFRESH_DIV(4), .BLANK_LZ(0)) dut_nolz (
        .clk(clk), .rst_n(rst_n), .opc(opc), .signc(signc), .res_valid(res_valid),
        .busy(busy_b), .done(done_b), .an(an_b), .seg(seg_b), .dp(dp_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic [7:0] v, input logic s);
        @(posedge clk); #1;
        opc = v; signc = s; res_valid = 1'b1;
        @(posedge clk); #1;
        res_valid = 1'b0;
    endtask

    task automatic wait_done(output int bc, output bit seen);
        bc = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) bc++;
        end
    endtask

    task automatic expect_display(input string tag, input logic [27:0] ea, input logic [27:0] eb);
        logic [3:0][6:0] da, db, xa, xb;
        da = 'x; db = 'x; xa = ea; xb = eb;
        repeat (16) begin
            @(negedge clk);
            case (an)
                4'b1110: da[0] = seg;
                4'b1101: da[1] = seg;
                4'b1011: da[2] = seg;
                4'b0111: da[3] = seg;
                default: ;
            endcase
            case (an_b)
                4'b1110: db[0] = seg_b;
                4'b1101: db[1] = seg_b;
                4'b1011: db[2] = seg_b;
                4'b0111: db[3] = seg_b;
                default: ;
            endcase
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_lz_d%0d", tag, i), 32'(da[i]), 32'(xa[i]));
            check($sformatf("%s_nolz_d%0d", tag, i), 32'(db[i]), 32'(xb[i]));
        end
    endtask

    task automatic convert_and_check(input string tag, input logic [7:0] v, input logic s);
        int bc;
        bit seen;
        pulse(v, s);
        wait_done(bc, seen);
        check({tag, "_busy_cycles"}, 32'(bc), 32'd8);
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  bc;
        bit  seen;
        bit  any_done;
        logic [3:0] prev;
        int  run;
        bit  first;

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_an", 32'(an), 32'h0000_000f);
        check("rst_seg", 32'(seg), 32'(BLK));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dp", 32'(dp), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_an", 32'(an), 32'h0000_000e);
        check("rel_seg", 32'(seg), 32'(S0));

        convert_and_check("v225", 8'd225, 1'b0);
        expect_display("v225", {BLK, S2, S2, S5}, {BLK, S2, S2, S5});

        convert_and_check("v7neg", 8'd7, 1'b1);
        expect_display("v7neg", {MIN, BLK, BLK, S7}, {MIN, S0, S0, S7});

        convert_and_check("negzero", 8'd0, 1'b1);
        expect_display("negzero", {BLK, BLK, BLK, S0}, {BLK, S0, S0, S0});

        // Second strobe lands in the 3rd SHIFT cycle and must be dropped.
        pulse(8'd255, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        opc = 8'd9; res_valid = 1'b1;
        @(posedge clk); #1;
        res_valid = 1'b0;
        wait_done(bc, seen);
        check("ign_busy_left", 32'(bc), 32'd5);
        check("ign_done_seen", 32'(seen), 32'd1);
        @(negedge clk);
        check("ign_done_one_cycle", 32'(done), 32'd0);
        expect_display("v255", {BLK, S2, S5, S5}, {BLK, S2, S5, S5});

        // A strobe during DONE is accepted immediately.
        pulse(8'd255, 1'b0);
        wait_done(bc, seen);
        check("dn_first_done", 32'(seen), 32'd1);
        opc = 8'd9; res_valid = 1'b1;
        @(posedge clk); #1;
        res_valid = 1'b0;
        wait_done(bc, seen);
        check("dn_busy_cycles", 32'(bc), 32'd8);
        check("dn_done_seen", 32'(seen), 32'd1);
        @(negedge clk);
        expect_display("v9", {BLK, BLK, BLK, S9}, {BLK, S0, S0, S9});

        // Reset in the 5th SHIFT cycle aborts the conversion.
        pulse(8'd128, 1'b1);
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_an", 32'(an), 32'h0000_000f);
        check("abort_seg", 32'(seg), 32'(BLK));
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_rel_an", 32'(an), 32'h0000_000e);
        check("abort_rel_seg", 32'(seg), 32'(S0));
        any_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            any_done |= done;
        end
        check("abort_no_done", 32'(any_done), 32'd0);
        expect_display("abort", {BLK, BLK, BLK, S0}, {BLK, S0, S0, S0});

        // Free-run anode sweep.
        @(negedge clk);
        prev = an;
        run = 1;
        first = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            check("an_onehot", 32'($countones(~an)), 32'd1);
            if (an == prev) begin
                run++;
            end else begin
                if (!first) check("an_hold", 32'(run), 32'd4);
                check("an_order", 32'(an), 32'({prev[2:0], prev[3]}));
                first = 1'b0;
                run = 1;
                prev = an;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule

// File: doc/alu_result_display.md
ALU_RESULT_DISPLAY -- requirements
Module: alu_result_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles per displayed digit (1 kHz digit rate at 100 MHz).
REQ-002 SHALL have parameter BLANK_LZ, default 1, meaning leading-zero blanking of hundreds/tens when 1.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low; this polarity and synchronicity are fixed.
REQ-005 SHALL have port opc  input  8  unsigned ALU result magnitude, 0..255.
REQ-006 SHALL have port signc  input  1  ALU result sign, 1 = negative.
REQ-007 SHALL have port res_valid  input  1  one-cycle load strobe for opc/signc.
REQ-008 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when new display digits are loaded.
REQ-010 SHALL have port an  output  4  digit anodes, active-low, one-hot; an[3] leftmost.
REQ-011 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 SHALL have port dp  output  1  decimal point, active-low, held at 1.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-014 In IDLE or DONE, res_valid=1 SHALL capture opc and signc and enter SHIFT on the same edge.
REQ-015 res_valid SHALL be ignored while in SHIFT; there is no queueing.
REQ-016 SHIFT SHALL run exactly 8 cycles of double-dabble: add 3 to each BCD nibble >=5, then shift left one bit.
REQ-017 busy SHALL be high for exactly those 8 cycles.
REQ-018 On the edge ending the 8th SHIFT cycle, the FSM SHALL enter DONE and load hundreds/tens/ones and sign display registers.
REQ-019 done SHALL be high for the single DONE cycle; DONE SHALL then return to IDLE unless a new res_valid is accepted.
REQ-020 Latency: with res_valid sampled at edge N, the display registers SHALL change at edge N+8, and done SHALL be high during cycle N+8..N+9.
REQ-021 Display registers SHALL hold their value until the next completed conversion.
REQ-022 Conversion SHALL be exact for the full 0..255 range; hundreds digit maximum is 2.
REQ-023 Negative zero: if magnitude=0, the sign digit SHALL be blank regardless of signc.
REQ-024 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap.
REQ-025 On wrap, the digit index SHALL advance 0->1->2->3->0.
REQ-026 Digit 0 SHALL show ones and SHALL never be blanked.
REQ-027 Digit 1 SHALL show tens; it SHALL be blank if BLANK_LZ=1 and hundreds=0 and tens=0.
REQ-028 Digit 2 SHALL show hundreds; it SHALL be blank if BLANK_LZ=1 and hundreds=0.
REQ-029 Digit 3 SHALL show '-' (seg=7'b0111111) when sign is shown; otherwise it SHALL be blank (7'b1111111).
REQ-030 an and seg SHALL be registered; they SHALL reflect the current digit index one cycle after the index changes.
REQ-031 Display update SHALL be glitch-free: digit registers SHALL change only on a DONE load edge.

Reset
REQ-032 While rst_n=0, the FSM SHALL be in IDLE with busy=0, done=0, dp=1.
REQ-033 While rst_n=0, all BCD/shift/display registers, the refresh counter and the digit index SHALL be 0.
REQ-034 While rst_n=0, an SHALL be 4'b1111 and seg SHALL be 7'b1111111.
REQ-035 On the first edge after release, an=4'b1110 and seg=7'b1000000 ("0").
REQ-036 Reset asserted mid-conversion SHALL abort it; no done SHALL be issued, and the display SHALL show "   0".

Structure
REQ-037 Package alu_disp_pkg SHALL hold the FSM state enum, the SEG_BLANK/SEG_MINUS constants and the 0-9 segment table.
REQ-038 Sub-module bin2bcd_seq SHALL contain the 8-cycle shift/add-3 datapath and the FSM, exposing start/busy/done and 12-bit BCD.
REQ-039 The top level SHALL contain display registers, refresh counter, digit mux and segment decode.

Verification (bench uses REFRESH_DIV=4)
REQ-040 opc=225, signc=0, res_valid pulse -> busy high 8 cycles, done pulse, display reads blank,2,2,5.
REQ-041 opc=7, signc=1 -> an sweep shows '-',blank,blank,7; with BLANK_LZ=0 it shows '-',0,0,7.
REQ-042 opc=0, signc=1 (multiply-by-zero case) -> sign digit blank, display reads "   0".
REQ-043 opc=255 accepted, then res_valid with opc=9 at the 3rd SHIFT cycle -> second strobe ignored; result 255; res_valid with opc=9 during DONE -> accepted, result 9.
REQ-044 rst_n low at the 5th SHIFT cycle of opc=128 -> no done; after release an=4'b1110, seg=7'b1000000.
REQ-045 Free-run 64 cycles -> an cycles 1110,1101,1011,0111 with each state held exactly 4 cycles; always one-hot low.
